// File: rtl/tone_detector_pkg.sv
// tone_detector_pkg: default timing for the piezo tone receiver and its state encoding
package tone_detector_pkg;
    localparam int M_6             = 37936;
    localparam int HALF_PERIOD_DEF = M_6 + 1;
    localparam int TOL_DEF         = 64;
    localparam int LOCK_COUNT_DEF  = 4;
    localparam int CNT_W_DEF       = 17;
    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
endpackage

// File: rtl/tone_detector_if.sv
// tone_detector_if: control, tone line and status signals of the tone detector
interface tone_detector_if import tone_detector_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
);
    logic             enable;
    logic             tone_in;
    logic             tone_present;
    logic             edge_err;
    logic [CNT_W-1:0] half_period;
    modport master (output enable, tone_in, input tone_present, half_period, edge_err);
    modport slave  (input enable, tone_in, output tone_present, half_period, edge_err);
endinterface

// File: rtl/tone_detector_sync_edge.sv
// tone_detector_sync_edge: three-flop synchroniser with a one-cycle pulse on either input edge
module tone_detector_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic edge_out
);
    logic s1, s2, s3;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) {s1, s2, s3} <= '0;
        else       {s1, s2, s3} <= {din, s1, s2};
    assign edge_out = s2 ^ s3;
endmodule

// File: rtl/tone_detector.sv
// tone_detector: locks onto a square-wave tone whose edge spacing stays within HALF_PERIOD +/- TOL
module tone_detector import tone_detector_pkg::*; #(
    parameter int HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int TOL         = TOL_DEF,
    parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input logic            clk,
    input logic            rstn,
    tone_detector_if.slave bus
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W:0]   LO  = (CNT_W+1)'(HALF_PERIOD - TOL);
    localparam logic [CNT_W:0]   HI  = (CNT_W+1)'(HALF_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(HALF_PERIOD + TOL);
    logic             tog, good, tmo, present, err;
    logic [CNT_W-1:0] cnt, hp;
    logic [CNT_W:0]   n;
    logic [GW-1:0]    good_cnt, good_nxt;
    state_t           state;
    tone_detector_sync_edge u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .din      (bus.tone_in),
        .edge_out (tog)
    );
    assign n        = {1'b0, cnt} + (CNT_W+1)'(1);
    assign good     = n >= LO && n <= HI;
    assign tmo      = cnt >= TMO;
    assign good_nxt = good_cnt + GW'(1);
    // an edge coinciding with the timeout threshold is still measured as an interval
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            cnt      <= '0;
            good_cnt <= '0;
            state    <= IDLE;
            present  <= 1'b0;
            hp       <= '0;
            err      <= 1'b0;
        end else if (!bus.enable) begin
            cnt      <= '0;
            good_cnt <= '0;
            state    <= IDLE;
            present  <= 1'b0;
            err      <= 1'b0;
        end else begin
            cnt <= tog ? '0 : (&cnt ? cnt : cnt + CNT_W'(1));
            err <= 1'b0;
            if (tog && state == IDLE) begin
                state    <= MEASURE;
                good_cnt <= '0;
            end else if (tog) begin
                hp <= &cnt ? cnt : n[CNT_W-1:0];
                if (!good) begin
                    err      <= 1'b1;
                    good_cnt <= '0;
                    present  <= 1'b0;
                    state    <= MEASURE;
                end else if (state == MEASURE) begin
                    good_cnt <= good_nxt;
                    if (good_nxt == GW'(LOCK_COUNT)) begin
                        state   <= LOCKED;
                        present <= 1'b1;
                    end
                end
            end else if (state != IDLE && tmo) begin
                state    <= IDLE;
                present  <= 1'b0;
                good_cnt <= '0;
            end
        end
    assign bus.tone_present = present;
    assign bus.half_period  = hp;
    assign bus.edge_err     = err;
endmodule

// File: tb/tb_tone_detector.sv
// tb_tone_detector: directed tone patterns with hand-computed lock, error and timeout expectations
module tb_tone_detector;
    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    always #5 clk = ~clk;
    tone_detector_if #(.CNT_W(17)) bus ();
    tone_detector #(
        .HALF_PERIOD (100),
        .TOL         (4),
        .LOCK_COUNT  (4),
        .CNT_W       (17)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );
    always @(negedge clk) if (bus.edge_err) pulses++;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic tog(input int n);
        bus.tone_in = ~bus.tone_in;
        step(n);
    endtask
    initial begin
        int p;
        rstn        = 1'b0;
        bus.enable  = 1'b0;
        bus.tone_in = 1'b0;
        #12;
        check("rst_present", bus.tone_present, 0);
        check("rst_hp", bus.half_period, 0);
        check("rst_err", bus.edge_err, 0);
        rstn = 1'b1;
        step(3);
        bus.enable = 1'b1;
        step(5);
        p = pulses;
        repeat (4) tog(100);
        tog(2);
        check("lock_early", bus.tone_present, 0);
        step(1);
        check("lock", bus.tone_present, 1);
        check("lock_hp", bus.half_period, 100);
        check("lock_no_err", pulses - p, 0);
        step(104);
        check("tmo_before", bus.tone_present, 1);
        step(1);
        check("tmo_fall", bus.tone_present, 0);
        check("tmo_hp", bus.half_period, 100);
        check("tmo_no_err", pulses - p, 0);
        p = pulses;
        repeat (5) tog(90);
        tog(5);
        check("fast_pulses", pulses - p, 5);
        check("fast_present", bus.tone_present, 0);
        check("fast_hp", bus.half_period, 90);
        step(200);
        repeat (5) tog(110);
        check("slow_present", bus.tone_present, 0);
        p = pulses;
        tog(96);
        tog(104);
        tog(96);
        tog(104);
        tog(3);
        check("bounds_lock", bus.tone_present, 1);
        check("bounds_hp", bus.half_period, 104);
        step(92);
        tog(3);
        check("err95", bus.edge_err, 1);
        check("err95_present", bus.tone_present, 0);
        check("err95_hp", bus.half_period, 95);
        step(1);
        check("err95_one_cycle", bus.edge_err, 0);
        step(101);
        tog(3);
        check("err105", bus.edge_err, 1);
        check("err105_hp", bus.half_period, 105);
        step(97);
        repeat (3) tog(100);
        tog(3);
        check("bounds_relock", bus.tone_present, 1);
        check("bounds_pulses", pulses - p, 2);
        p = pulses;
        step(47);
        tog(3);
        check("glitch_err", bus.edge_err, 1);
        check("glitch_present", bus.tone_present, 0);
        check("glitch_hp", bus.half_period, 50);
        step(97);
        repeat (3) tog(100);
        tog(2);
        check("glitch_relock_early", bus.tone_present, 0);
        step(1);
        check("glitch_relock", bus.tone_present, 1);
        check("glitch_relock_hp", bus.half_period, 100);
        check("glitch_pulses", pulses - p, 1);
        step(50);
        rstn = 1'b0;
        #2;
        check("arst_present", bus.tone_present, 0);
        check("arst_hp", bus.half_period, 0);
        check("arst_err", bus.edge_err, 0);
        bus.tone_in = 1'b0;
        #10;
        rstn = 1'b1;
        step(2);
        repeat (4) tog(100);
        tog(3);
        check("en_lock", bus.tone_present, 1);
        step(10);
        bus.enable = 1'b0;
        check("en_hold", bus.tone_present, 1);
        step(1);
        check("en_off_present", bus.tone_present, 0);
        check("en_off_hp", bus.half_period, 100);
        step(20);
        bus.enable = 1'b1;
        step(5);
        repeat (4) tog(100);
        tog(2);
        check("en_relock_early", bus.tone_present, 0);
        step(1);
        check("en_relock", bus.tone_present, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
